// File: rtl/slave_in_port.sv
// Slave-side serial receive stage: deserialises address, burst length and write data,
// then issues one memory-core request per word with a core_ready handshake.
module slave_in_port #(
  parameter int SLAVE_ADDR_SIZE = 12,
  parameter int WORD_SIZE       = 8,
  parameter int BURST_SIZE      = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sel,
  input  logic                       rd_mode,
  input  logic                       burst_mode,
  input  logic                       addr_bit,
  input  logic                       addr_valid,
  input  logic                       burst_bit,
  input  logic                       burst_valid,
  input  logic                       wdata_bit,
  input  logic                       wdata_valid,
  input  logic                       core_ready,
  output logic                       s_ready,
  output logic [SLAVE_ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]       mem_wdata,
  output logic                       mem_wr,
  output logic                       mem_rd,
  output logic [BURST_SIZE-1:0]      burst_len,
  output logic                       rx_done,
  output logic                       rx_err
);

  localparam int CNT_W = $clog2(SLAVE_ADDR_SIZE + BURST_SIZE + WORD_SIZE);

  typedef enum logic [2:0] {
    IDLE, ADDR_RX, BURST_RX, DATA_RX, WR_OUT, READ_REQ, DONE
  } state_t;

  state_t                     state_q,     state_d;
  logic [CNT_W-1:0]           bit_cnt_q,   bit_cnt_d;
  logic [SLAVE_ADDR_SIZE-1:0] addr_sh_q,   addr_sh_d;
  logic [BURST_SIZE-1:0]      burst_sh_q,  burst_sh_d;
  logic [WORD_SIZE-1:0]       wdata_sh_q,  wdata_sh_d;
  logic [BURST_SIZE-1:0]      word_cnt_q,  word_cnt_d;
  logic                       rd_mode_q,   rd_mode_d;
  logic [SLAVE_ADDR_SIZE-1:0] mem_addr_q,  mem_addr_d;
  logic [WORD_SIZE-1:0]       mem_wdata_q, mem_wdata_d;
  logic [BURST_SIZE-1:0]      burst_len_q, burst_len_d;
  logic                       mem_wr_q,    mem_wr_d;
  logic                       mem_rd_q,    mem_rd_d;
  logic                       rx_done_q,   rx_done_d;
  logic                       rx_err_q,    rx_err_d;
  logic                       s_ready_q,   s_ready_d;

  // Shift right so the LSB-first stream ends up in natural bit order
  logic [SLAVE_ADDR_SIZE-1:0] addr_word;
  logic [BURST_SIZE-1:0]      burst_word;
  logic [WORD_SIZE-1:0]       data_word;
  logic                       last_word;
  logic                       abort;

  assign addr_word  = {addr_bit,  addr_sh_q[SLAVE_ADDR_SIZE-1:1]};
  assign burst_word = {burst_bit, burst_sh_q[BURST_SIZE-1:1]};
  assign data_word  = {wdata_bit, wdata_sh_q[WORD_SIZE-1:1]};
  assign last_word  = (word_cnt_q == burst_len_q - BURST_SIZE'(1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_sh_d   = addr_sh_q;
    burst_sh_d  = burst_sh_q;
    wdata_sh_d  = wdata_sh_q;
    word_cnt_d  = word_cnt_q;
    rd_mode_d   = rd_mode_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    burst_len_d = burst_len_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    rx_err_d    = 1'b0;
    abort       = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel && addr_valid) begin
          addr_sh_d = addr_word;
          bit_cnt_d = CNT_W'(1);
          state_d   = ADDR_RX;
        end
      end
      ADDR_RX: begin
        if (!sel) begin
          abort = 1'b1;
        end else if (addr_valid) begin
          addr_sh_d = addr_word;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(SLAVE_ADDR_SIZE - 1)) begin
            mem_addr_d = addr_word;
            rd_mode_d  = rd_mode;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            if (burst_mode) begin
              state_d = BURST_RX;
            end else begin
              burst_len_d = BURST_SIZE'(1);
              state_d     = rd_mode ? READ_REQ : DATA_RX;
              mem_rd_d    = rd_mode;
            end
          end
        end
      end
      BURST_RX: begin
        if (!sel) begin
          abort = 1'b1;
        end else if (burst_valid) begin
          burst_sh_d = burst_word;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(BURST_SIZE - 1)) begin
            // A zero length still moves one word
            burst_len_d = (burst_word == '0) ? BURST_SIZE'(1) : burst_word;
            bit_cnt_d   = '0;
            state_d     = rd_mode_q ? READ_REQ : DATA_RX;
            mem_rd_d    = rd_mode_q;
          end
        end
      end
      DATA_RX: begin
        if (!sel) begin
          abort = 1'b1;
        end else if (wdata_valid) begin
          wdata_sh_d = data_word;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(WORD_SIZE - 1)) begin
            mem_wdata_d = data_word;
            mem_wr_d    = 1'b1;
            bit_cnt_d   = '0;
            state_d     = WR_OUT;
          end
        end
      end
      WR_OUT: begin
        if (core_ready) begin
          mem_wr_d   = 1'b0;
          mem_addr_d = mem_addr_q + SLAVE_ADDR_SIZE'(1);
          word_cnt_d = word_cnt_q + BURST_SIZE'(1);
          state_d    = last_word ? DONE : DATA_RX;
        end
        abort = !sel;
      end
      READ_REQ: begin
        if (core_ready) begin
          mem_addr_d = mem_addr_q + SLAVE_ADDR_SIZE'(1);
          word_cnt_d = word_cnt_q + BURST_SIZE'(1);
          if (last_word) begin
            mem_rd_d = 1'b0;
            state_d  = DONE;
          end
        end
        abort = !sel;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A handshake on the abort cycle has already been accounted for above
    if (abort) begin
      state_d   = IDLE;
      mem_wr_d  = 1'b0;
      mem_rd_d  = 1'b0;
      bit_cnt_d = '0;
      rx_err_d  = 1'b1;
    end

    rx_done_d = (state_d == DONE);
    s_ready_d = core_ready && (state_d inside {IDLE, ADDR_RX, BURST_RX, DATA_RX});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      addr_sh_q   <= '0;
      burst_sh_q  <= '0;
      wdata_sh_q  <= '0;
      word_cnt_q  <= '0;
      rd_mode_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      burst_len_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_err_q    <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_sh_q   <= addr_sh_d;
      burst_sh_q  <= burst_sh_d;
      wdata_sh_q  <= wdata_sh_d;
      word_cnt_q  <= word_cnt_d;
      rd_mode_q   <= rd_mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      burst_len_q <= burst_len_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      rx_done_q   <= rx_done_d;
      rx_err_q    <= rx_err_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_rd    = mem_rd_q;
  assign burst_len = burst_len_q;
  assign rx_done   = rx_done_q;
  assign rx_err    = rx_err_q;

endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: serial write/read transactions, stalls, abort and reset.
module tb_slave_in_port;

  logic        clk, rst_n, sel, rd_mode, burst_mode;
  logic        addr_bit, addr_valid, burst_bit, burst_valid, wdata_bit, wdata_valid;
  logic        core_ready, s_ready, mem_wr, mem_rd, rx_done, rx_err;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [14:0] burst_len;

  int n_cmp = 0;
  int n_err = 0;
  int wr_hs = 0, rd_hs = 0, done_cnt = 0, err_cnt = 0;
  int wr0, rd0, dn0, er0;

  slave_in_port dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rd_mode(rd_mode), .burst_mode(burst_mode),
    .addr_bit(addr_bit), .addr_valid(addr_valid), .burst_bit(burst_bit),
    .burst_valid(burst_valid), .wdata_bit(wdata_bit), .wdata_valid(wdata_valid),
    .core_ready(core_ready), .s_ready(s_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd), .burst_len(burst_len),
    .rx_done(rx_done), .rx_err(rx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters observed at the active edge
  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_wr && core_ready) wr_hs++;
      if (mem_rd && core_ready) rd_hs++;
      if (rx_done) done_cnt++;
      if (rx_err) err_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    wr0 = wr_hs; rd0 = rd_hs; dn0 = done_cnt; er0 = err_cnt;
  endtask

  task automatic send_addr(input logic [11:0] a, input logic rd, input logic bm);
    sel = 1'b1; rd_mode = rd; burst_mode = bm;
    for (int i = 0; i < 12; i++) begin
      addr_bit = a[i]; addr_valid = 1'b1;
      step();
    end
    addr_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [14:0] l);
    for (int i = 0; i < 15; i++) begin
      burst_bit = l[i]; burst_valid = 1'b1;
      step();
    end
    burst_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      wdata_bit = d[i]; wdata_valid = 1'b1;
      step();
    end
    wdata_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; rd_mode = 1'b0; burst_mode = 1'b0;
    addr_bit = 1'b0; addr_valid = 1'b0; burst_bit = 1'b0; burst_valid = 1'b0;
    wdata_bit = 1'b0; wdata_valid = 1'b0; core_ready = 1'b1;

    // Reset state
    step(); step();
    check("rst_s_ready", s_ready, 0);
    check("rst_outputs", {mem_wr, mem_rd, rx_done, rx_err, mem_addr, mem_wdata, burst_len}, 0);
    rst_n = 1'b1;
    step();
    check("idle_s_ready", s_ready, 1);

    // Reset in the middle of a 4-word burst write, after two words
    snap();
    send_addr(12'h100, 1'b0, 1'b1);
    send_burst(15'd4);
    check("mid_burst_len", burst_len, 4);
    send_bits(8'h11, 8); step();
    send_bits(8'h22, 8); step();
    check("mid_two_writes", wr_hs - wr0, 2);
    check("mid_addr_adv", mem_addr, 12'h102);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outputs", {mem_wr, mem_rd, rx_done, rx_err, mem_addr, mem_wdata, burst_len}, 0);
    check("mid_rst_s_ready", s_ready, 0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_no_wr", {mem_wr, mem_rd}, 0);

    // Single write, address 0xA5C, data 0x3C
    snap();
    send_addr(12'hA5C, 1'b0, 1'b0);
    check("sw_addr", mem_addr, 12'hA5C);
    check("sw_len", burst_len, 1);
    send_bits(8'h3C, 8);
    check("sw_wr", mem_wr, 1);
    check("sw_wdata", mem_wdata, 8'h3C);
    check("sw_addr_hold", mem_addr, 12'hA5C);
    step();
    check("sw_wr_drop", mem_wr, 0);
    check("sw_done", rx_done, 1);
    step();
    check("sw_done_pulse", rx_done, 0);
    check("sw_counts", {wr_hs - wr0, done_cnt - dn0}, {32'd1, 32'd1});

    // Burst write wrapping the address space: 0xFFE, 0xFFF, 0x000
    snap();
    send_addr(12'hFFE, 1'b0, 1'b1);
    send_burst(15'd3);
    check("bw_len", burst_len, 3);
    send_bits(8'h11, 8);
    check("bw_a0", {mem_wr, mem_addr, mem_wdata}, {1'b1, 12'hFFE, 8'h11});
    step();
    send_bits(8'h22, 8);
    check("bw_a1", {mem_wr, mem_addr, mem_wdata}, {1'b1, 12'hFFF, 8'h22});
    step();
    send_bits(8'h33, 8);
    check("bw_a2", {mem_wr, mem_addr, mem_wdata}, {1'b1, 12'h000, 8'h33});
    step();
    check("bw_done", rx_done, 1);
    step();
    check("bw_counts", {wr_hs - wr0, done_cnt - dn0}, {32'd3, 32'd1});

    // Burst read with core_ready toggling
    snap();
    send_addr(12'h010, 1'b1, 1'b1);
    send_burst(15'd4);
    check("br_rd_rise", mem_rd, 1);
    for (int k = 0; k < 4; k++) begin
      core_ready = 1'b0;
      step();
      check("br_rd_hold", {mem_rd, s_ready, mem_addr}, {1'b1, 1'b0, 12'h010 + 12'(k)});
      core_ready = 1'b1;
      step();
    end
    check("br_end", {mem_rd, rx_done, mem_addr}, {1'b0, 1'b1, 12'h014});
    step();
    check("br_counts", {rd_hs - rd0, wr_hs - wr0, done_cnt - dn0}, {32'd4, 32'd0, 32'd1});

    // Core stall for 5 cycles while a write is pending
    snap();
    send_addr(12'h123, 1'b0, 1'b0);
    send_bits(8'h5A, 8);
    core_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_hold", {mem_wr, s_ready, mem_addr, mem_wdata}, {1'b1, 1'b0, 12'h123, 8'h5A});
    end
    check("stall_no_wr", wr_hs - wr0, 0);
    core_ready = 1'b1;
    step();
    check("stall_release", {mem_wr, rx_done}, 2'b01);
    step();
    check("stall_counts", wr_hs - wr0, 1);

    // sel dropped after 3 data bits
    snap();
    send_addr(12'h200, 1'b0, 1'b0);
    send_bits(8'hFF, 3);
    sel = 1'b0;
    step();
    check("abort_err", {rx_err, mem_wr}, 2'b10);
    sel = 1'b1;
    step();
    check("abort_err_pulse", rx_err, 0);
    step();
    check("abort_counts", {wr_hs - wr0, err_cnt - er0, done_cnt - dn0}, {32'd0, 32'd1, 32'd0});

    // Burst length 0 received: exactly one word transferred
    snap();
    send_addr(12'h300, 1'b0, 1'b1);
    send_burst(15'd0);
    check("len0_len", burst_len, 1);
    send_bits(8'h77, 8);
    check("len0_wr", {mem_wr, mem_addr, mem_wdata}, {1'b1, 12'h300, 8'h77});
    step();
    check("len0_done", {mem_wr, rx_done, mem_addr}, {1'b0, 1'b1, 12'h301});
    step(); step();
    check("len0_counts", {wr_hs - wr0, done_cnt - dn0}, {32'd1, 32'd1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
